ddr_wr_arb: RTL and testbench
=============================

DDR_WR_ARB -- requirements
Module: ddr_wr_arb

Interface
REQ-001 Parameter BLEN, default 16: number of 32-bit words per granted burst; legal range 1..256.
REQ-002 Port clk, input, 1: single system clock; all logic is on the rising edge.
REQ-003 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 Port enb, input, 1: arbitration enable.
REQ-005 Ports req0 / req1, input, 1: burst request from requester 0 (rect output) / requester 1 (bm output); held high until ack.
REQ-006 Ports ack0 / ack1, output, 1: one-cycle grant acknowledge to requester 0 / 1.
REQ-007 Ports dout0 / dout1, input, 32: write data from requester 0 / 1.
REQ-008 Ports strb0 / strb1, input, 4: byte strobes from requester 0 / 1.
REQ-009 Ports vout0 / vout1, input, 1: data-valid from requester 0 / 1.
REQ-010 Port ddr_req, output, 1: burst request to the DDR write master.
REQ-011 Port ddr_ack, input, 1: one-cycle acknowledge from the DDR write master.
REQ-012 Ports ddr_dout / ddr_strb / ddr_vout, output, 32 / 4 / 1: forwarded write data, strobes and valid.
REQ-013 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have three states:
- IDLE -> GRANT when enb=1 and (req0|req1).
- GRANT -> XFER on ddr_ack.
- XFER -> IDLE after the BLEN-th granted vout word has been forwarded.
REQ-015 On the IDLE->GRANT transition, the winner is latched into gnt:
- only one request pending: that requester wins.
- both pending: the requester other than last_gnt wins (round-robin).
- last_gnt resets to 1, so requester 0 wins the first tie.
REQ-016 ddr_req SHALL be registered: set on entry to GRANT, cleared in the cycle ddr_ack is sampled.
REQ-017 ack0 = ddr_ack & GRANT & (gnt==0); ack1 = ddr_ack & GRANT & (gnt==1). Combinational, zero latency.
REQ-018 last_gnt SHALL update to gnt on ddr_ack.
REQ-019 In XFER, the granted requester's dout/strb/vout SHALL be registered onto ddr_dout/ddr_strb/ddr_vout with exactly 1-cycle latency.
REQ-020 ddr_vout SHALL be 0 whenever the block is not in XFER.
REQ-021 Word counter (9-bit) SHALL clear on entry to XFER and increment on each granted vout.
REQ-022 When the counter reaches BLEN-1 and a granted vout arrives, the FSM SHALL go to IDLE on the next edge; the final word still appears on ddr_vout one cycle later.
REQ-023 Back-to-back bursts are allowed: after XFER->IDLE, the next GRANT entry may occur 1 cycle later.
REQ-024 vout from the non-granted requester, or any vout outside XFER, SHALL be dropped and not forwarded.
REQ-025 enb deasserted during GRANT or XFER SHALL NOT abort the burst; no new grant is issued while enb=0.
REQ-026 A ddr_ack outside GRANT SHALL be ignored.
REQ-027 A request deasserted during GRANT SHALL NOT cancel the grant; the arbiter completes the burst handshake regardless.

Reset
REQ-028 While rst_n=0, all outputs SHALL be 0 (ddr_req, ack0, ack1, ddr_dout, ddr_strb, ddr_vout, busy, err); state=IDLE, last_gnt=1, counter=0.
REQ-029 Reset asserted mid-burst SHALL abandon the burst immediately; no residual ddr_vout after release.

Configuration
REQ-030 Macro DDR_WR_ARB_ERR_EN defined: adds output err (1 bit), a sticky flag set by any vout dropped under REQ-024, cleared only by rst_n or by enb low for one cycle.
REQ-031 Macro DDR_WR_ARB_ERR_EN undefined: no err port and no err logic; dropping behaviour is unchanged.

Verification
REQ-032 BLEN=4, req0 only, ddr_ack 3 cycles after ddr_req, 4 consecutive vout0 words 0xA0..0xA3 -> ack0 pulses once, ddr_vout carries 0xA0..0xA3 each 1 cycle late, busy falls after word 4.
REQ-033 req0 and req1 asserted in the same cycle after reset, each serviced in turn -> grant order 0,1,0,1; ack0/ack1 never high together.
REQ-034 vout1=1 with data 0xDEAD during a requester-0 burst -> 0xDEAD is not forwarded; err=1 when DDR_WR_ARB_ERR_EN is defined.
REQ-035 enb cleared 1 cycle after ddr_ack with req1 pending -> current burst completes with all BLEN words; no further grant until enb=1.
REQ-036 rst_n pulsed low after 2 of 4 words -> all outputs 0 during reset; IDLE after release; a new req0 is then granted normally with counter=0.

Source files
------------

// File: rtl/ddr_wr_arb.sv
// Two-requester round-robin arbiter that forwards one BLEN-word write burst to a DDR write master.
// Optional sticky drop-error output enabled by defining DDR_WR_ARB_ERR_EN.
module ddr_wr_arb #(
    parameter int unsigned BLEN = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enb,
    input  logic        req0,
    input  logic        req1,
    output logic        ack0,
    output logic        ack1,
    input  logic [31:0] dout0,
    input  logic [31:0] dout1,
    input  logic [3:0]  strb0,
    input  logic [3:0]  strb1,
    input  logic        vout0,
    input  logic        vout1,
    output logic        ddr_req,
    input  logic        ddr_ack,
    output logic [31:0] ddr_dout,
    output logic [3:0]  ddr_strb,
    output logic        ddr_vout,
    output logic        busy
`ifdef DDR_WR_ARB_ERR_EN
    ,
    output logic        err
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        XFER
    } state_t;

    localparam logic [8:0] LAST_IDX = 9'(BLEN - 1);

    state_t      state, state_nxt;
    logic        gnt, gnt_nxt;
    logic        last_gnt;
    logic [8:0]  cnt;
    logic        g_vout;
    logic [31:0] g_dout;
    logic [3:0]  g_strb;
    logic        fwd;
    logic        ack_hit;

    // Data path of whichever requester currently holds the grant.
    assign g_vout  = gnt ? vout1 : vout0;
    assign g_dout  = gnt ? dout1 : dout0;
    assign g_strb  = gnt ? strb1 : strb0;
    assign fwd     = (state == XFER) && g_vout;
    assign ack_hit = (state == GRANT) && ddr_ack;

    assign ack0 = ack_hit && !gnt;
    assign ack1 = ack_hit && gnt;
    assign busy = (state != IDLE);

    // NOTE: every signal driven here gets a default first so no latch is inferred on idle paths.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        case (state)
            IDLE: begin
                if (enb && (req0 || req1)) begin
                    state_nxt = GRANT;
                    // On a tie the requester that was not served last wins.
                    gnt_nxt   = (req0 && req1) ? ~last_gnt : req1;
                end
            end
            GRANT: begin
                if (ddr_ack) state_nxt = XFER;
            end
            XFER: begin
                if (g_vout && (cnt == LAST_IDX)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
            ddr_req  <= 1'b0;
            cnt      <= '0;
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            ddr_req <= (state_nxt == GRANT);
            if (ack_hit) begin
                last_gnt <= gnt;
                cnt      <= '0;
            end else if (fwd) begin
                cnt <= cnt + 9'd1;
            end
        end
    end

    // Forwarded beat lags the requester by one cycle; non-granted beats are squashed to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ddr_vout <= 1'b0;
            ddr_dout <= '0;
            ddr_strb <= '0;
        end else begin
            ddr_vout <= fwd;
            ddr_dout <= fwd ? g_dout : '0;
            ddr_strb <= fwd ? g_strb : '0;
        end
    end

`ifdef DDR_WR_ARB_ERR_EN
    logic drop;

    assign drop = (state == XFER) ? (gnt ? vout0 : vout1) : (vout0 || vout1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (!enb) begin
            err <= 1'b0;
        end else if (drop) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ddr_wr_arb.sv
// Scoreboard bench for ddr_wr_arb with BLEN=4: forwarded words, grant order, reset and enable handling.
module tb_ddr_wr_arb;

    localparam int BLEN = 4;

    logic        clk;
    logic        rst_n;
    logic        enb;
    logic        req0, req1;
    logic        ack0, ack1;
    logic [31:0] dout0, dout1;
    logic [3:0]  strb0, strb1;
    logic        vout0, vout1;
    logic        ddr_req;
    logic        ddr_ack;
    logic [31:0] ddr_dout;
    logic [3:0]  ddr_strb;
    logic        ddr_vout;
    logic        busy;
`ifdef DDR_WR_ARB_ERR_EN
    logic        err;
`endif

    int n_checks;
    int n_errors;

    logic [35:0] sb[$];
    int          got_order[$];

    ddr_wr_arb #(.BLEN(BLEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enb      (enb),
        .req0     (req0),
        .req1     (req1),
        .ack0     (ack0),
        .ack1     (ack1),
        .dout0    (dout0),
        .dout1    (dout1),
        .strb0    (strb0),
        .strb1    (strb1),
        .vout0    (vout0),
        .vout1    (vout1),
        .ddr_req  (ddr_req),
        .ddr_ack  (ddr_ack),
        .ddr_dout (ddr_dout),
        .ddr_strb (ddr_strb),
        .ddr_vout (ddr_vout),
        .busy     (busy)
`ifdef DDR_WR_ARB_ERR_EN
        ,
        .err      (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int w, input logic v, input logic [31:0] d, input logic [3:0] s);
        if (w == 0) begin
            vout0 = v; dout0 = d; strb0 = s;
        end else begin
            vout1 = v; dout1 = d; strb1 = s;
        end
    endtask

    task automatic check_reset_outs();
        check("rst_outs", {ddr_req, ack0, ack1, ddr_dout, ddr_strb, ddr_vout, busy}, 64'd0);
`ifdef DDR_WR_ARB_ERR_EN
        check("rst_err", err, 1'b0);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        repeat (2) tick();
        @(negedge clk);
        check_reset_outs();
        tick();
        rst_n = 1'b1;
    endtask

    // Services one grant for requester w: handshake, BLEN words, optional re-request afterwards.
    task automatic serve(input int w, input int dly, input logic [31:0] base, input int gap,
                         input bit noise, input bit drop_enb, input bit rereq);
        int n;
        n = 0;
        while (!ddr_req && n < 50) begin
            tick();
            n++;
        end
        check("ddr_req_seen", ddr_req, 1'b1);
        repeat (dly - 1) tick();
        ddr_ack = 1'b1;
        @(negedge clk);
        check("ack0", ack0, (w == 0));
        check("ack1", ack1, (w == 1));
        tick();
        ddr_ack = 1'b0;
        if (w == 0) req0 = 1'b0; else req1 = 1'b0;
        if (drop_enb) enb = 1'b0;
        for (int i = 0; i < BLEN; i++) begin
            repeat (gap) tick();
            drive(w, 1'b1, base + 32'(i), 4'(i + 1));
            sb.push_back({4'(i + 1), base + 32'(i)});
            if (noise && i == 1) drive(1 - w, 1'b1, 32'hDEAD, 4'hF);
            if (i == BLEN - 1) begin
                @(negedge clk);
                check("busy_pre_last", busy, 1'b1);
            end
            tick();
            drive(0, 1'b0, 32'd0, 4'd0);
            drive(1, 1'b0, 32'd0, 4'd0);
        end
        @(negedge clk);
        check("busy_done", busy, 1'b0);
        if (rereq) begin
            if (w == 0) req0 = 1'b1; else req1 = 1'b1;
        end
    endtask

    // Output monitor: compares forwarded beats against the scoreboard and logs grants.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ddr_vout) begin
                if (sb.size() == 0) check("ddr_vout_unexp", ddr_vout, 1'b0);
                else check("ddr_data", {ddr_strb, ddr_dout}, sb.pop_front());
            end
            if (ack0 || ack1) begin
                check("ack_excl", ack0 && ack1, 1'b0);
                got_order.push_back(ack1 ? 1 : 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[4];
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0; enb = 1'b0; req0 = 1'b0; req1 = 1'b0; ddr_ack = 1'b0;
        drive(0, 1'b0, 32'd0, 4'd0);
        drive(1, 1'b0, 32'd0, 4'd0);
        #2;
        check_reset_outs();
        do_reset();

        // Single requester burst, ack three cycles after ddr_req.
        enb = 1'b1;
        req0 = 1'b1;
        got_order.delete();
        serve(0, 3, 32'hA0, 0, 1'b0, 1'b0, 1'b0);
        check("single_ack_count", got_order.size(), 1);

        // Stray ddr_ack while idle must be ignored.
        tick();
        ddr_ack = 1'b1;
        @(negedge clk);
        check("stray_ack", {ack0, ack1, busy}, 3'b000);
        tick();
        ddr_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_req", {ddr_req, busy}, 2'b00);

        // Simultaneous requests after reset alternate 0,1,0,1.
        do_reset();
        got_order.delete();
        req0 = 1'b1;
        req1 = 1'b1;
        serve(0, 1, 32'hC0, 0, 1'b0, 1'b0, 1'b1);
        serve(1, 2, 32'hD0, 1, 1'b0, 1'b0, 1'b1);
        serve(0, 1, 32'hC4, 0, 1'b0, 1'b0, 1'b0);
        serve(1, 1, 32'hD4, 0, 1'b0, 1'b0, 1'b0);
        exp_order = '{0, 1, 0, 1};
        check("order_len", got_order.size(), 4);
        for (int i = 0; i < 4 && i < got_order.size(); i++)
            check("grant_order", got_order[i], exp_order[i]);

        // Non-granted vout during a requester-0 burst is dropped.
        req0 = 1'b1;
        serve(0, 2, 32'hE0, 0, 1'b1, 1'b0, 1'b0);
`ifdef DDR_WR_ARB_ERR_EN
        check("err_set", err, 1'b1);
        tick();
        enb = 1'b0;
        tick();
        enb = 1'b1;
        @(negedge clk);
        check("err_clr", err, 1'b0);
`endif

        // enb dropped after ack with req1 pending: burst completes, then no new grant.
        tick();
        req0 = 1'b1;
        tick();
        req1 = 1'b1;
        serve(0, 2, 32'hF0, 0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            check("enb_hold", {ddr_req, busy}, 2'b00);
        end
        enb = 1'b1;
        serve(1, 1, 32'h1F0, 0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a burst abandons it.
        tick();
        req0 = 1'b1;
        begin
            int n;
            n = 0;
            while (!ddr_req && n < 50) begin
                tick();
                n++;
            end
        end
        check("mid_ddr_req", ddr_req, 1'b1);
        ddr_ack = 1'b1;
        tick();
        ddr_ack = 1'b0;
        req0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(0, 1'b1, 32'hB0 + 32'(i), 4'hF);
            sb.push_back({4'hF, 32'hB0 + 32'(i)});
            tick();
        end
        drive(0, 1'b0, 32'd0, 4'd0);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check_reset_outs();
        @(negedge clk);
        check_reset_outs();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_idle", {busy, ddr_vout, ddr_req}, 3'b000);
            tick();
        end
        req0 = 1'b1;
        serve(0, 2, 32'h70, 0, 1'b0, 1'b0, 1'b0);

        repeat (3) tick();
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
